// File: rtl/ga_rand_arb_pkg.sv
// Shared sizing helpers and types for the GA random-chunk arbiter.
// Widths are derived from the top-level parameters through these functions.
package ga_rand_arb_pkg;

    localparam int DEF_RAND_W  = 42;
    localparam int DEF_CHUNK_W = 14;

    typedef logic [DEF_CHUNK_W-1:0] chunk_t;

    // The arbiter is EMPTY exactly when no unused chunk remains in the pool.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SERVE = 1'b1
    } arb_state_e;

    function automatic int chunks_f(input int rand_w, input int chunk_w);
        return rand_w / chunk_w;
    endfunction

    function automatic int avail_w_f(input int chunks);
        return $clog2(chunks + 1);
    endfunction

    function automatic int ptr_w_f(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/ga_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module ga_rr_picker
    import ga_rand_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptr_w_f(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [PTR_W-1:0]   winner_o,
    output logic               any_req_o
);

    logic [NUM_REQ-1:0] rot;
    logic [PTR_W:0]     sum;

    // Rotate so bit 0 is the requester at ptr; scanning high to low leaves the
    // lowest rotated offset as the final winner.
    always_comb begin
        rot      = NUM_REQ'(({req_i, req_i} >> ptr_i));
        sum      = '0;
        winner_o = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (rot[off]) begin
                sum = {1'b0, ptr_i} + (PTR_W+1)'(off);
                if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                    sum = sum - (PTR_W+1)'(NUM_REQ);
                end
                winner_o = sum[PTR_W-1:0];
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/ga_rand_chunk_arbiter.sv
// Buffers one generator word and hands it out chunk by chunk (LSB first) to
// NUM_REQ requesters in round-robin order, never reusing a bit.
module ga_rand_chunk_arbiter
    import ga_rand_arb_pkg::*;
#(
    parameter int SIM_DLY = 1,
    parameter int RAND_W  = 42,
    parameter int CHUNK_W = 14,
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_rst,
    input  logic [RAND_W-1:0]  rand_42bit,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [CHUNK_W-1:0] rand_chunk,
    output logic               rand_vld,
    output logic               pool_empty,
    output logic [15:0]        word_cnt
);

    localparam int CHUNKS  = chunks_f(RAND_W, CHUNK_W);
    localparam int AVAIL_W = avail_w_f(CHUNKS);
    localparam int PTR_W   = ptr_w_f(NUM_REQ);

    if (RAND_W % CHUNK_W != 0) begin : g_bad_chunk_w
        $error("RAND_W must be an exact multiple of CHUNK_W");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must lie in 2..8");
    end
    if (SIM_DLY < 0) begin : g_bad_sim_dly
        $error("SIM_DLY must not be negative");
    end

    logic [RAND_W-1:0]  pool_q,  pool_d;
    logic [AVAIL_W-1:0] avail_q, avail_d;
    logic [PTR_W-1:0]   ptr_q,   ptr_d;
    logic [NUM_REQ-1:0] gnt_q,   gnt_d;
    logic [CHUNK_W-1:0] chunk_q, chunk_d;
    logic               empty_q, empty_d;
    logic [15:0]        wcnt_q,  wcnt_d;

    arb_state_e         state;
    logic [PTR_W-1:0]   winner;
    logic               any_req;

    ga_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pool_q  <= '0;
            avail_q <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            chunk_q <= '0;
            empty_q <= 1'b1;
            wcnt_q  <= '0;
        end else begin
            pool_q  <= pool_d;
            avail_q <= avail_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            chunk_q <= chunk_d;
            empty_q <= empty_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // A refill cycle never grants, so the pool is only read once it is loaded.
    always_comb begin
        state   = (avail_q == '0) ? ST_EMPTY : ST_SERVE;
        pool_d  = pool_q;
        avail_d = avail_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        chunk_d = chunk_q;
        wcnt_d  = wcnt_q;
        if (sw_rst) begin
            pool_d  = '0;
            avail_d = '0;
            ptr_d   = '0;
            chunk_d = '0;
            wcnt_d  = '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    pool_d  = rand_42bit;
                    avail_d = AVAIL_W'(CHUNKS);
                    wcnt_d  = wcnt_q + 16'd1;
                end
                ST_SERVE: begin
                    if (any_req) begin
                        gnt_d   = NUM_REQ'(1) << winner;
                        chunk_d = pool_q[CHUNK_W-1:0];
                        pool_d  = pool_q >> CHUNK_W;
                        avail_d = avail_q - AVAIL_W'(1);
                        ptr_d   = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
                    end
                end
                default: begin
                    avail_d = '0;
                end
            endcase
        end
        empty_d = (avail_d == '0);
    end

    assign gnt        = gnt_q;
    assign rand_chunk = chunk_q;
    assign rand_vld   = |gnt_q;
    assign pool_empty = empty_q;
    assign word_cnt   = wcnt_q;

endmodule

// File: tb/tb_ga_rand_chunk_arbiter.sv
// Self-checking bench for ga_rand_chunk_arbiter: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ga_rand_chunk_arbiter;

   localparam int RAND_W  = 42;
   localparam int CHUNK_W = 14;
   localparam int NUM_REQ = 4;
   localparam int CHUNKS  = RAND_W / CHUNK_W;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                swReset = 1'b0;
   logic [RAND_W-1:0]   randWord = '0;
   logic [NUM_REQ-1:0]  req = '0;
   logic [NUM_REQ-1:0]  gnt;
   logic [CHUNK_W-1:0]  randChunk;
   logic                randVld;
   logic                poolEmpty;
   logic [15:0]         wordCnt;

   int checkCount = 0;
   int passCount  = 0;
   bit checkEn    = 1'b0;
   bit logEn      = 1'b0;
   int grantLog[$];

   logic [CHUNK_W-1:0]  modelQ[$];
   int                  modelPtr = 0;
   logic [15:0]         expWordCnt = '0;
   logic [NUM_REQ-1:0]  expGnt = '0;
   logic [CHUNK_W-1:0]  expChunk = '0;
   bit                  expEmpty = 1'b1;

   ga_rand_chunk_arbiter #(
      .SIM_DLY (1),
      .RAND_W  (RAND_W),
      .CHUNK_W (CHUNK_W),
      .NUM_REQ (NUM_REQ)
   ) dut (
      .clk        (clock),
      .rst        (reset),
      .sw_rst     (swReset),
      .rand_42bit (randWord),
      .req        (req),
      .gnt        (gnt),
      .rand_chunk (randChunk),
      .rand_vld   (randVld),
      .pool_empty (poolEmpty),
      .word_cnt   (wordCnt)
   );

   always #500 clock = ~clock;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      modelQ.delete();
      modelPtr   = 0;
      expWordCnt = '0;
      expGnt     = '0;
      expChunk   = '0;
      expEmpty   = 1'b1;
   endtask

   // The model keeps unused chunks as a queue and picks winners by a plain
   // modular search, then records what the registered outputs must show.
   task automatic modelStep();
      int  winner;
      bit  found;
      if (reset || swReset) begin
         modelReset();
      end else if (modelQ.size() == 0) begin
         for (int k = 0; k < CHUNKS; k++) begin
            modelQ.push_back(randWord[k*CHUNK_W +: CHUNK_W]);
         end
         expWordCnt = expWordCnt + 16'd1;
         expGnt     = '0;
      end else if (req != '0) begin
         winner = 0;
         found  = 1'b0;
         for (int off = 0; off < NUM_REQ; off++) begin
            if (!found && req[(modelPtr + off) % NUM_REQ]) begin
               winner = (modelPtr + off) % NUM_REQ;
               found  = 1'b1;
            end
         end
         expGnt   = NUM_REQ'(1) << winner;
         expChunk = modelQ.pop_front();
         modelPtr = (winner + 1) % NUM_REQ;
      end else begin
         expGnt = '0;
      end
      expEmpty = (modelQ.size() == 0);
   endtask

   initial begin
      forever begin
         @(posedge clock or posedge reset);
         modelStep();
      end
   end

   // Compare every output against the model midway between active edges.
   always @(negedge clock) begin
      if (checkEn) begin
         checkOutput("gnt", gnt, expGnt);
         checkOutput("rand_chunk", randChunk, expChunk);
         checkOutput("rand_vld", randVld, |expGnt);
         checkOutput("pool_empty", poolEmpty, expEmpty);
         checkOutput("word_cnt", wordCnt, expWordCnt);
      end
      if (logEn && gnt != '0) begin
         int idx;
         idx = -1;
         if ($onehot(gnt)) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (gnt[i]) idx = i;
            end
         end
         grantLog.push_back(idx);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] reqVal, input bit swVal);
      req     = reqVal;
      swReset = swVal;
   endtask

   task automatic doSwReset();
      applyStimulus('0, 1'b1);
      tick();
      checkOutput("swrst gnt", gnt, 4'b0000);
      checkOutput("swrst word_cnt", wordCnt, 16'd0);
      checkOutput("swrst pool_empty", poolEmpty, 1'b1);
      swReset = 1'b0;
   endtask

   initial begin
      logic [RAND_W-1:0] word;
      int perReq[NUM_REQ];

      // Reset and first load with a known word.
      randWord = {14'h3AAA, 14'h1555, 14'h0123};
      repeat (2) tick();
      checkOutput("reset gnt", gnt, 4'b0000);
      checkOutput("reset pool_empty", poolEmpty, 1'b1);
      checkOutput("reset word_cnt", wordCnt, 16'd0);
      checkOutput("reset rand_chunk", randChunk, 14'h0);
      checkEn = 1'b1;
      reset   = 1'b0;
      applyStimulus(4'b0001, 1'b0);
      tick();
      checkOutput("load bubble gnt", gnt, 4'b0000);
      checkOutput("load word_cnt", wordCnt, 16'd1);
      tick();
      checkOutput("chunk0 gnt", gnt, 4'b0001);
      checkOutput("chunk0 data", randChunk, 14'h0123);
      tick();
      checkOutput("chunk1 data", randChunk, 14'h1555);
      tick();
      checkOutput("chunk2 data", randChunk, 14'h3AAA);
      checkOutput("chunk2 pool_empty", poolEmpty, 1'b1);
      tick();
      checkOutput("second bubble gnt", gnt, 4'b0000);
      checkOutput("second word_cnt", wordCnt, 16'd2);

      // Round-robin with all requesters active.
      doSwReset();
      grantLog.delete();
      applyStimulus(4'b1111, 1'b0);
      logEn = 1'b1;
      repeat (12) tick();
      logEn = 1'b0;
      req   = '0;
      checkOutput("rr grant count", grantLog.size(), 8);
      for (int i = 0; i < NUM_REQ; i++) perReq[i] = 0;
      for (int i = 0; i < grantLog.size() && i < 8; i++) begin
         checkOutput("rr order", grantLog[i], i % NUM_REQ);
         if (grantLog[i] >= 0 && grantLog[i] < NUM_REQ) perReq[grantLog[i]]++;
      end
      for (int i = 0; i < NUM_REQ; i++) checkOutput("rr fairness", perReq[i], 2);

      // Sparse requests skip idle requesters.
      doSwReset();
      grantLog.delete();
      applyStimulus(4'b1010, 1'b0);
      logEn = 1'b1;
      repeat (7) tick();
      logEn = 1'b0;
      req   = '0;
      checkOutput("sparse grant count", grantLog.size(), 4);
      for (int i = 0; i < grantLog.size() && i < 4; i++) begin
         checkOutput("sparse order", grantLog[i], (i % 2 == 0) ? 1 : 3);
      end

      // Holding a partly used word while nobody asks.
      doSwReset();
      word     = RAND_W'({$urandom(), $urandom()});
      randWord = word;
      tick();
      checkOutput("hold load word_cnt", wordCnt, 16'd1);
      applyStimulus(4'b0100, 1'b0);
      tick();
      checkOutput("hold first gnt", gnt, 4'b0100);
      checkOutput("hold first chunk", randChunk, word[13:0]);
      req = '0;
      for (int i = 0; i < 5; i++) begin
         randWord = RAND_W'({$urandom(), $urandom()});
         tick();
         checkOutput("idle gnt", gnt, 4'b0000);
         checkOutput("idle word_cnt", wordCnt, 16'd1);
         checkOutput("idle pool_empty", poolEmpty, 1'b0);
      end
      req = 4'b0100;
      tick();
      checkOutput("resume chunk1", randChunk, word[27:14]);
      tick();
      checkOutput("resume chunk2", randChunk, word[41:28]);
      checkOutput("resume pool_empty", poolEmpty, 1'b1);
      req = '0;

      // Soft reset in the middle of a word.
      doSwReset();
      applyStimulus(4'b1111, 1'b0);
      tick();
      tick();
      checkOutput("mid-word gnt", gnt, 4'b0001);
      swReset = 1'b1;
      tick();
      checkOutput("swrst edge gnt", gnt, 4'b0000);
      checkOutput("swrst edge word_cnt", wordCnt, 16'd0);
      swReset = 1'b0;
      tick();
      checkOutput("post swrst bubble", gnt, 4'b0000);
      checkOutput("post swrst word_cnt", wordCnt, 16'd1);
      tick();
      checkOutput("post swrst first gnt", gnt, 4'b0001);
      req = '0;

      // Asynchronous reset between edges while a grant is showing.
      doSwReset();
      applyStimulus(4'b1111, 1'b0);
      tick();
      tick();
      checkOutput("pre async gnt", gnt, 4'b0001);
      #299;
      reset = 1'b1;
      #1;
      checkOutput("async gnt", gnt, 4'b0000);
      checkOutput("async rand_vld", randVld, 1'b0);
      checkOutput("async rand_chunk", randChunk, 14'h0);
      checkOutput("async pool_empty", poolEmpty, 1'b1);
      tick();
      reset = 1'b0;
      tick();
      checkOutput("after async bubble", gnt, 4'b0000);
      checkOutput("after async word_cnt", wordCnt, 16'd1);

      // Randomized traffic with occasional soft resets.
      for (int i = 0; i < 3000; i++) begin
         randWord = RAND_W'({$urandom(), $urandom()});
         applyStimulus(NUM_REQ'($urandom_range(0, 15)), ($urandom_range(0, 63) == 0));
         tick();
      end
      applyStimulus('0, 1'b0);
      tick();
      @(negedge clock);
      #1;
      checkEn = 1'b0;

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/ga_rand_chunk_arbiter.md
Name: ga_rand_chunk_arbiter

Overview:
- Shares the free-running 42-bit random word from ga_42bit_rand_gen among NUM_REQ GA consumers, such as the selection, crossover-point and mutation units.
- Buffers one word, splits it into CHUNK_W-bit chunks and grants one chunk per cycle to a requester, using round-robin arbitration.
- Guarantees that no random bit is handed out twice.
- Sits between the generator output and the GA operator blocks.

Parameters:
- SIM_DLY, 1: register output delay for simulation, matching the generator.
- RAND_W, 42: width of the generator word.
- CHUNK_W, 14: bits delivered per grant. RAND_W % CHUNK_W must be 0, and elaboration fails otherwise.
- NUM_REQ, 4: number of requesters, range 2..8.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- sw_rst  in  1  synchronous soft reset, active-high.
- rand_42bit  in  RAND_W  generator word, which may change every cycle.
- req  in  NUM_REQ  per-requester request, level: one chunk wanted per cycle while high.
- gnt  out  NUM_REQ  one-hot registered grant, asserted for 1 cycle per chunk.
- rand_chunk  out  CHUNK_W  chunk data, valid with gnt.
- rand_vld  out  1  equals |gnt.
- pool_empty  out  1  high when the buffer holds no unused chunk.
- word_cnt  out  16  count of words loaded since reset, wraps at 0xFFFF->0.

Behaviour:
- Reset is asynchronous and active-high on rst; the design uses one clock, clk.
- While rst is high, all state is cleared at once: gnt=0, rand_chunk=0, rand_vld=0, pool_empty=1, word_cnt=0, pool=0, avail=0, ptr=0.
- sw_rst is synchronous and active-high. When sampled high it clears the same state as rst at the next edge. It has priority over refill and grant in the same cycle.
- Internal state:
  - pool[RAND_W-1:0].
  - avail: 0..CHUNKS, where CHUNKS = RAND_W/CHUNK_W.
  - ptr: round-robin pointer, 0..NUM_REQ-1.
- State machine, two states derived from avail:
  - EMPTY (avail==0): at the next edge, pool<=rand_42bit, avail<=CHUNKS, word_cnt++. No grant is issued this cycle, even with req high; this is a 1-cycle refill bubble.
  - SERVE (avail>0): if |req, the winner w is the first set req bit searching from ptr upward with wrap. At the next edge:
    - gnt<=onehot(w), rand_chunk<=pool[CHUNK_W-1:0], pool<=pool>>CHUNK_W (zero fill), avail--, ptr<=(w+1)%NUM_REQ.
    - If no req: gnt<=0, and rand_chunk holds its last value. pool, avail and ptr are unchanged.
- Chunk order within a word: LSB chunk first.
- Latency: req sampled at edge t gives gnt/rand_chunk at edge t+1 (registered).
- Requesters drop req once enough requests are issued. Every gnt is a consumed chunk and cannot be refused.
- After the last chunk (avail 1->0), the following cycle is EMPTY and loads a new word. Sustained throughput is CHUNKS grants per CHUNKS+1 cycles.
- pool_empty is registered and equals (avail==0).
- Simultaneous requests: exactly one grant per cycle, never more.
- A requester whose req is low is skipped, and ptr does not move to it.
- Reset mid-operation discards the remaining chunks. The first cycle after release is EMPTY.

Decomposition:
- Package ga_rand_arb_pkg:
  - CHUNKS constant function.
  - avail width: $clog2(CHUNKS+1).
  - ptr width: $clog2(NUM_REQ).
  - typedef for the chunk word.
- Sub-module ga_rr_picker (combinational): inputs req and ptr; outputs winner index and any_req. Parameterised by NUM_REQ.
- The top level holds pool, counters and output registers.

Test Plan:
- Reset and first load:
  - Stimulus: rst high, then low; rand_42bit={14'h3AAA,14'h1555,14'h0123}; req=4'b0001 held.
  - Response: pool_empty=1 and word_cnt=0 during reset. One bubble, then word_cnt=1. gnt=0001 for 3 consecutive cycles with chunks 0x0123, 0x1555, 0x3AAA. One bubble, then the next word.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held for 12 cycles.
  - Response: grants rotate 0,1,2,3,0,... across bubbles. Each requester gets exactly 2 grants in 8 grants, and no cycle has more than one gnt bit.
- Sparse requests:
  - Stimulus: req=4'b1010 with ptr=0.
  - Response: grants go 1,3,1,3, with indices 0 and 2 never granted.
- No request while holding a word:
  - Stimulus: load a word, take 1 chunk, then req=0 for 5 cycles, then req=0100.
  - Response: avail stays 2 and word_cnt does not change. The next two grants carry chunks 2 and 3 of the same word.
- sw_rst mid-word:
  - Stimulus: after 1 chunk of a word, pulse sw_rst with req=1111.
  - Response: no gnt in the edge following sw_rst. word_cnt=0, ptr=0, then a bubble and a fresh load. The first grant after that goes to requester 0.
- Async reset between edges:
  - Stimulus: assert rst 300 time units after a posedge while gnt is high.
  - Response: gnt, rand_vld and rand_chunk go to 0 without waiting for the next edge.
